// File: rtl/amo_sequencer.sv
// Purpose : multicycle RV32A AMO sequencer (read word, ALU op with rs2, write back, return old word).
// Latency : accept at cycle 0 -> rsp_valid at cycle 4 with zero-wait memory; error rsp at cycle 1.
// Backpr. : req_ready low while busy; READ/WRITE hold the memory request until mem_ready.
//
// Ports:
//   clk, reset                           clock, async active-high reset
//   req_valid/req_ready/req_funct5/
//   req_addr/req_rs2                     AMO request from the control FSM
//   mem_valid/mem_ready/mem_wr/mem_addr/
//   mem_wdata/mem_rdata                  word port towards the memory arbiter
//   alu_a/alu_b/alu_ctrl/alu_result      shared ALU operands, op select and result
//   rsp_valid/rsp_rdata/rsp_error        completion pulse, original word, error flag
module amo_sequencer #(
    parameter int ALU_CTRL_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [4:0]                req_funct5,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_rs2,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic                      mem_wr,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    output logic [31:0]               alu_a,
    output logic [31:0]               alu_b,
    output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
    input  logic [31:0]               alu_result,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_error
);

    // ALU operation codes understood by the shared ALU.
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD  = ALU_CTRL_WIDTH'(0);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR  = ALU_CTRL_WIDTH'(1);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR   = ALU_CTRL_WIDTH'(2);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND  = ALU_CTRL_WIDTH'(3);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MIN  = ALU_CTRL_WIDTH'(4);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MAX  = ALU_CTRL_WIDTH'(5);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MINU = ALU_CTRL_WIDTH'(6);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_MAXU = ALU_CTRL_WIDTH'(7);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_LUI  = ALU_CTRL_WIDTH'(8);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CALC,
        WRITE,
        RESP
    } state_t;

    state_t                    state;
    logic [ALU_CTRL_WIDTH-1:0] map_ctrl;
    logic                      map_ok;

    // funct5 decode; LR/SC and anything else not listed are rejected.
    always_comb begin
        map_ctrl = ALU_ADD;
        map_ok   = 1'b1;
        case (req_funct5)
            5'b00000: map_ctrl = ALU_ADD;
            5'b00100: map_ctrl = ALU_XOR;
            5'b01000: map_ctrl = ALU_OR;
            5'b01100: map_ctrl = ALU_AND;
            5'b10000: map_ctrl = ALU_MIN;
            5'b10100: map_ctrl = ALU_MAX;
            5'b11000: map_ctrl = ALU_MINU;
            5'b11100: map_ctrl = ALU_MAXU;
            5'b00001: map_ctrl = ALU_LUI;   // SWAP: ALU passes operand b through
            default:  map_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_valid <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= ALU_ADD;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        mem_addr  <= req_addr;
                        alu_b     <= req_rs2;
                        alu_ctrl  <= map_ctrl;
                        if (!map_ok || (req_addr[1:0] != 2'b00)) begin
                            // Rejected request: answer straight away, no memory traffic.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                        end else begin
                            state     <= READ;
                            mem_valid <= 1'b1;
                            mem_wr    <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (mem_ready) begin
                        alu_a     <= mem_rdata;
                        rsp_rdata <= mem_rdata;
                        mem_valid <= 1'b0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    // ALU is combinational on alu_a/alu_b/alu_ctrl, all stable here.
                    mem_wdata <= alu_result;
                    mem_valid <= 1'b1;
                    mem_wr    <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_wr    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_valid <= 1'b0;
                    mem_wr    <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amo_sequencer.sv
// Purpose : self-checking bench for amo_sequencer with memory responder, ALU and AMO reference model.
// Latency : n/a (bench).
// Backpr. : memory responder inserts a programmable number of wait cycles per request.
module tb_amo_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_funct5;
    logic [31:0] req_addr;
    logic [31:0] req_rs2;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    amo_sequencer #(.ALU_CTRL_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct5(req_funct5),
        .req_addr(req_addr), .req_rs2(req_rs2),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    // Shared ALU as seen by the sequencer.
    always_comb begin
        alu_result = 32'h0;
        case (alu_ctrl)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a ^ alu_b;
            4'd2: alu_result = alu_a | alu_b;
            4'd3: alu_result = alu_a & alu_b;
            4'd4: alu_result = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
            4'd5: alu_result = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
            4'd6: alu_result = (alu_a < alu_b) ? alu_a : alu_b;
            4'd7: alu_result = (alu_a > alu_b) ? alu_a : alu_b;
            4'd8: alu_result = alu_b;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    // Memory model, responder and bus monitor.
    logic [31:0] mem [logic [31:0]];
    logic [63:0] wr_q [$];
    int          mem_wait = 0;
    int          wcnt = 0;
    int          rsp_cnt = 0;
    int          mv_cnt = 0;
    int          stab_err = 0;
    int          b2b_err = 0;
    bit          prev_valid = 0;
    bit          hs_prev = 0;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_wr;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
    end

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rsp_cnt++;
        if (mem_valid === 1'b1) mv_cnt++;
        if (mem_valid === 1'b1 && prev_valid &&
            (mem_addr !== prev_addr || mem_wr !== prev_wr || (mem_wr && mem_wdata !== prev_wdata)))
            stab_err++;
        if (mem_valid === 1'b1 && hs_prev) b2b_err++;
        mem_ready = 1'b0;
        mem_rdata = $urandom();
        if (mem_valid === 1'b1) begin
            if (wcnt >= mem_wait) begin
                mem_ready = 1'b1;
                wcnt = 0;
                if (mem_wr) begin
                    mem[mem_addr] = mem_wdata;
                    wr_q.push_back({mem_addr, mem_wdata});
                end else begin
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
        hs_prev    = (mem_valid === 1'b1) && mem_ready;
        prev_valid = (mem_valid === 1'b1) && !mem_ready;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_wr    = mem_wr;
    end

    // Reference AMO semantics: returns 1 when the op is legal, nw = word to store.
    function automatic bit ref_amo(input logic [4:0] f, input logic [31:0] a,
                                   input logic [31:0] old, input logic [31:0] b,
                                   output logic [31:0] nw);
        bit ok;
        ok = 1'b1;
        nw = 32'h0;
        case (f)
            5'b00000: nw = old + b;
            5'b00100: nw = old ^ b;
            5'b01000: nw = old | b;
            5'b01100: nw = old & b;
            5'b10000: nw = ($signed(old) <= $signed(b)) ? old : b;
            5'b10100: nw = ($signed(old) >= $signed(b)) ? old : b;
            5'b11000: nw = (old <= b) ? old : b;
            5'b11100: nw = (old >= b) ? old : b;
            5'b00001: nw = b;
            default:  ok = 1'b0;
        endcase
        if (a % 4 != 0) ok = 1'b0;
        return ok;
    endfunction

    // Issue one request and wait (bounded) for its response pulse.
    task automatic do_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int w, output bit got, output logic err,
                         output logic [31:0] rd, output int lat);
        int n;
        mem_wait = w;
        got = 0; err = 0; rd = 0; lat = 0;
        @(negedge clk);
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_funct5 = f; req_addr = a; req_rs2 = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (n < 100) begin
            if (rsp_valid === 1'b1) begin
                got = 1; err = rsp_error; rd = rsp_rdata; lat = n;
                break;
            end
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        tests++; if (mem_valid !== 1'b0 || mem_wr !== 1'b0) begin fails++; $display("FAIL reset_mem got valid=%b wr=%b exp 0 0", mem_valid, mem_wr); end
        tests++; if (rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin fails++; $display("FAIL reset_rsp got valid=%b err=%b exp 0 0", rsp_valid, rsp_error); end
        tests++; if ({rsp_rdata, alu_a, alu_b, mem_addr, mem_wdata} !== 160'h0) begin fails++; $display("FAIL reset_data got rd=%h a=%h b=%h addr=%h wd=%h exp 0", rsp_rdata, alu_a, alu_b, mem_addr, mem_wdata); end
        tests++; if (alu_ctrl !== 4'd0) begin fails++; $display("FAIL reset_alu_ctrl got=%0d exp=0", alu_ctrl); end
    endtask

    // Directed and randomized AMOs checked against the reference model.
    task automatic check_amo(input string nm, input logic [4:0] f, input logic [31:0] a,
                             input logic [31:0] old, input logic [31:0] b, input int w);
        bit got, ok;
        logic err;
        logic [31:0] rd, nw;
        int lat, rc0, wq0, mv0, se0, exp_lat;
        logic [63:0] wr;
        mem[a] = old;
        ok = ref_amo(f, a, old, b, nw);
        exp_lat = ok ? 4 + 2 * w : 1;
        rc0 = rsp_cnt; wq0 = wr_q.size(); mv0 = mv_cnt; se0 = stab_err;
        do_op(f, a, b, w, got, err, rd, lat);
        tests++; if (!got) begin fails++; $display("FAIL %s_rsp_timeout no rsp_valid", nm); end
        tests++; if (err !== !ok) begin fails++; $display("FAIL %s_error got=%b exp=%b", nm, err, !ok); end
        tests++; if (lat != exp_lat) begin fails++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, exp_lat); end
        tests++; if (rsp_cnt - rc0 != 1) begin fails++; $display("FAIL %s_rsp_pulses got=%0d exp=1", nm, rsp_cnt - rc0); end
        if (ok) begin
            tests++; if (rd !== old) begin fails++; $display("FAIL %s_rdata got=%h exp=%h", nm, rd, old); end
            tests++;
            if (wr_q.size() != wq0 + 1) begin
                fails++; $display("FAIL %s_write_count got=%0d exp=1", nm, wr_q.size() - wq0);
            end else begin
                wr = wr_q[wq0];
                if (wr !== {a, nw}) begin fails++; $display("FAIL %s_write got=%h exp=%h", nm, wr, {a, nw}); end
            end
            tests++; if (stab_err != se0) begin fails++; $display("FAIL %s_bus_stable got=%0d violations exp=0", nm, stab_err - se0); end
        end else begin
            tests++; if (mv_cnt != mv0 || wr_q.size() != wq0) begin fails++; $display("FAIL %s_no_mem got=%0d valid cycles exp=0", nm, mv_cnt - mv0); end
        end
    endtask

    task automatic test_directed;
        check_amo("amoadd",  5'b00000, 32'h100, 32'hFFFF_FFFF, 32'h2, 0);
        check_amo("amomin",  5'b10000, 32'h104, 32'h8000_0000, 32'h1, 0);
        check_amo("amominu", 5'b11000, 32'h108, 32'h8000_0000, 32'h1, 0);
        check_amo("amoswap", 5'b00001, 32'h300, 32'h1234_5678, 32'hCAFE_BABE, 3);
        check_amo("misalign", 5'b00000, 32'h102, 32'h5, 32'h6, 0);
        check_amo("lr",      5'b00010, 32'h10C, 32'h7, 32'h8, 0);
        check_amo("sc",      5'b00011, 32'h110, 32'h7, 32'h8, 1);
    endtask

    task automatic test_random;
        logic [4:0] fl [9];
        logic [4:0] f;
        logic [31:0] a;
        int r;
        fl[0] = 5'b00000; fl[1] = 5'b00100; fl[2] = 5'b01000; fl[3] = 5'b01100; fl[4] = 5'b10000;
        fl[5] = 5'b10100; fl[6] = 5'b11000; fl[7] = 5'b11100; fl[8] = 5'b00001;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 11);
            f = (r < 9) ? fl[r] : ((r == 9) ? 5'b00010 : ((r == 10) ? 5'b00011 : 5'($urandom())));
            a = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            check_amo("rand", f, a, $urandom(), $urandom(), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_in_write;
        int n, rc0, wq0;
        bit got;
        logic err;
        logic [31:0] rd;
        int lat;
        mem[32'h500] = 32'hAAAA_5555;
        mem[32'h200] = 32'h0F0F_0000;
        mem_wait = 3;
        rc0 = rsp_cnt; wq0 = wr_q.size();
        @(negedge clk);
        req_valid = 1'b1; req_funct5 = 5'b00001; req_addr = 32'h500; req_rs2 = 32'h1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(mem_valid === 1'b1 && mem_wr === 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++; if (n >= 50) begin fails++; $display("FAIL rst_reach_write timeout"); end
        #1 reset = 1'b1;
        #1;
        tests++; if (mem_valid !== 1'b0 || mem_wr !== 1'b0) begin fails++; $display("FAIL rst_async_mem got valid=%b wr=%b exp 0 0", mem_valid, mem_wr); end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
        tests++; if (rsp_cnt != rc0) begin fails++; $display("FAIL rst_no_rsp got=%0d pulses exp=0", rsp_cnt - rc0); end
        tests++; if (wr_q.size() != wq0 || mem[32'h500] !== 32'hAAAA_5555) begin fails++; $display("FAIL rst_write_dropped got mem=%h exp=aaaa5555", mem[32'h500]); end
        do_op(5'b01000, 32'h200, 32'h0000_00FF, 0, got, err, rd, lat);
        tests++; if (!got || err !== 1'b0 || lat != 4) begin fails++; $display("FAIL rst_next_amoor got rsp=%0d err=%b lat=%0d exp 1 0 4", got, err, lat); end
        tests++; if (mem[32'h200] !== 32'h0F0F_00FF || rd !== 32'h0F0F_0000) begin fails++; $display("FAIL rst_next_amoor_data got mem=%h rd=%h exp 0f0f00ff 0f0f0000", mem[32'h200], rd); end
    endtask

    task automatic test_back_to_back;
        int acc [$];
        int rsp [$];
        logic [31:0] rds [$];
        int wq0;
        bit sw;
        logic [63:0] w0, w1;
        mem[32'h400] = 32'h1111_0000;
        mem[32'h404] = 32'hFFFF_0F0F;
        mem_wait = 0;
        wq0 = wr_q.size();
        sw = 0;
        @(negedge clk);
        req_valid = 1'b1; req_funct5 = 5'b00100; req_addr = 32'h400; req_rs2 = 32'h0000_1111;
        for (int k = 0; k < 20; k++) begin
            if (sw) begin
                sw = 0;
                if (acc.size() == 1) begin
                    req_addr = 32'h404; req_rs2 = 32'h0F0F_FFFF;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (rsp_valid === 1'b1) begin rsp.push_back(k); rds.push_back(rsp_rdata); end
            if (req_valid && req_ready === 1'b1) begin acc.push_back(k); sw = 1; end
            @(negedge clk);
        end
        req_valid = 1'b0;
        tests++;
        if (acc.size() != 2 || rsp.size() != 2) begin
            fails++; $display("FAIL b2b_counts got acc=%0d rsp=%0d exp 2 2", acc.size(), rsp.size());
        end else begin
            tests++; if (acc[1] - acc[0] != 5) begin fails++; $display("FAIL b2b_spacing got=%0d exp=5", acc[1] - acc[0]); end
            tests++; if (rsp[0] - acc[0] != 4 || rsp[1] - acc[1] != 4) begin fails++; $display("FAIL b2b_latency got=%0d,%0d exp 4,4", rsp[0] - acc[0], rsp[1] - acc[1]); end
            tests++; if (rds[0] !== 32'h1111_0000 || rds[1] !== 32'hFFFF_0F0F) begin fails++; $display("FAIL b2b_rdata got=%h,%h exp 11110000,ffff0f0f", rds[0], rds[1]); end
        end
        tests++;
        if (wr_q.size() != wq0 + 2) begin
            fails++; $display("FAIL b2b_writes got=%0d exp=2", wr_q.size() - wq0);
        end else begin
            w0 = wr_q[wq0]; w1 = wr_q[wq0 + 1];
            if (w0 !== 64'h0000_0400_1111_1111 || w1 !== 64'h0000_0404_F0F0_F0F0) begin
                fails++; $display("FAIL b2b_write_data got=%h,%h exp 0000040011111111,00000404f0f0f0f0", w0, w1);
            end
        end
        tests++; if (b2b_err != 0) begin fails++; $display("FAIL mem_valid_after_ready got=%0d exp=0", b2b_err); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_funct5 = 5'h0; req_addr = 32'h0; req_rs2 = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset;
        reset = 1'b0;
        test_directed;
        test_reset_in_write;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
